// File: rtl/prga_fifo_rr_arbiter.sv
// Round-robin merge of several lookahead FIFO read ports into one lookahead
// output stage, with a per-port burst limit before the scan rotates.
module prga_fifo_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int MAX_BURST  = 4,
  localparam int SRC_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            empty_i,
  output logic [NUM_PORTS-1:0]            rd_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] dout_i,
  output logic                            empty,
  input  logic                            rd,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic [SRC_W-1:0]                src
);

  localparam logic [7:0]       BURST_MAX = 8'(MAX_BURST);
  localparam logic [SRC_W-1:0] LAST_PORT = SRC_W'(NUM_PORTS - 1);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic [SRC_W-1:0]      ptr_q, ptr_d;
  logic [7:0]            burst_q, burst_d;

  logic                  loadable;
  logic                  found;
  logic                  pop;
  logic [SRC_W-1:0]      scanStart;
  logic [SRC_W-1:0]      sel;
  logic [SRC_W-1:0]      idx;
  int                    idxInt;

  // Scan starts at the current port while its burst budget remains, else at the next one.
  always_comb begin
    loadable = !rst && (!valid_q || rd);
    if (burst_q < BURST_MAX) begin
      scanStart = ptr_q;
    end else if (ptr_q == LAST_PORT) begin
      scanStart = '0;
    end else begin
      scanStart = ptr_q + SRC_W'(1);
    end

    found  = 1'b0;
    sel    = '0;
    idxInt = 0;
    idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idxInt = int'(scanStart) + i;
      if (idxInt >= NUM_PORTS) begin
        idxInt = idxInt - NUM_PORTS;
      end
      idx = idxInt[SRC_W-1:0];
      if (!found && !empty_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    pop  = loadable && found;
    rd_i = '0;
    if (pop) begin
      rd_i[sel] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    if (pop) begin
      valid_d = 1'b1;
      data_d  = dout_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      src_d   = sel;
      ptr_d   = sel;
      if ((sel == ptr_q) && (burst_q < BURST_MAX)) begin
        burst_d = burst_q + 8'd1;
      end else begin
        burst_d = 8'd1;
      end
    end else if (rd) begin
      valid_d = 1'b0;
    end
  end

  // Reset parks ptr on the last port with an exhausted burst so the first scan starts at port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= LAST_PORT;
      burst_q <= BURST_MAX;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  assign empty = !valid_q;
  assign dout  = data_q;
  assign src   = src_q;

endmodule

// File: tb/tb_prga_fifo_rr_arbiter.sv
// Directed bench: two arbiters (MAX_BURST 1 and 2) each fed by a small
// lookahead FIFO model per port.
module tb_prga_fifo_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] emptyI [2];
  logic [3:0] rdI    [2];
  logic [31:0] doutI [2];
  logic       emptyO [2];
  logic       rdDs   [2];
  logic [7:0] doutO  [2];
  logic [1:0] srcO   [2];

  logic [7:0] mem  [2][4][8];
  logic [3:0] head [2][4];
  logic [3:0] cnt  [2][4];

  int checks;
  int errors;

  logic [7:0] exp1 [12] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11,
                            8'h21, 8'h31, 8'h02, 8'h12, 8'h22, 8'h32};
  logic [7:0] exp2 [12] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21,
                            8'h30, 8'h31, 8'h02, 8'h12, 8'h22, 8'h32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    prga_fifo_rr_arbiter #(
      .DATA_WIDTH(8),
      .NUM_PORTS (4),
      .MAX_BURST (g + 1)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .empty_i(emptyI[g]),
      .rd_i   (rdI[g]),
      .dout_i (doutI[g]),
      .empty  (emptyO[g]),
      .rd     (rdDs[g]),
      .dout   (doutO[g]),
      .src    (srcO[g])
    );
    for (genvar p = 0; p < 4; p++) begin : gPort
      assign emptyI[g][p]        = (head[g][p] == cnt[g][p]);
      assign doutI[g][p*8 +: 8]  = mem[g][p][head[g][p][2:0]];
    end
  end

  task automatic clearModel();
    for (int g = 0; g < 2; g++) begin
      for (int p = 0; p < 4; p++) begin
        head[g][p] = 4'd0;
        cnt[g][p]  = 4'd0;
        for (int k = 0; k < 8; k++) mem[g][p][k] = 8'h00;
      end
    end
  endtask

  task automatic loadPort(input int g, input int p, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) mem[g][p][k] = base + 8'(k);
    head[g][p] = 4'd0;
    cnt[g][p]  = 4'(n);
  endtask

  // Capture the upstream pops just before the edge, then retire them in the model.
  task automatic tick();
    logic [3:0] r [2];
    #1;
    r[0] = rdI[0];
    r[1] = rdI[1];
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      for (int p = 0; p < 4; p++) begin
        if (r[g][p]) head[g][p] = head[g][p] + 4'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdDs[0] = 1'b0;
    rdDs[1] = 1'b0;
    clearModel();
    for (int g = 0; g < 2; g++) begin
      for (int p = 0; p < 4; p++) loadPort(g, p, 3, 8'(p << 4));
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (rdI[g] !== 4'b0000 || emptyO[g] !== 1'b1 || doutO[g] !== 8'h00 || srcO[g] !== 2'd0) begin
          errors++;
          $display("[TB] FAIL reset_state dut%0d: rd_i=%b empty=%b dout=%h src=%0d, expected 0000/1/00/0",
                   g, rdI[g], emptyO[g], doutO[g], srcO[g]);
        end
      end
      tick();
    end
    rst = 1'b0;
    rdDs[0] = 1'b1;
    rdDs[1] = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rdI[g] !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL first_select dut%0d: rd_i=%b expected 0001", g, rdI[g]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expRd;
    for (int i = 0; i < 12; i++) begin
      #1;
      expRd = 4'b0001 << exp1[i][5:4];
      checks++;
      if (rdI[0] !== expRd) begin
        errors++;
        $display("[TB] FAIL rr_rd_i[%0d]: got %b expected %b", i, rdI[0], expRd);
      end
      tick();
      checks++;
      if (emptyO[0] !== 1'b0 || doutO[0] !== exp1[i] || srcO[0] !== exp1[i][5:4]) begin
        errors++;
        $display("[TB] FAIL rr_burst1[%0d]: empty=%b dout=%h src=%0d expected 0/%h/%0d",
                 i, emptyO[0], doutO[0], srcO[0], exp1[i], exp1[i][5:4]);
      end
      checks++;
      if (emptyO[1] !== 1'b0 || doutO[1] !== exp2[i] || srcO[1] !== exp2[i][5:4]) begin
        errors++;
        $display("[TB] FAIL rr_burst2[%0d]: empty=%b dout=%h src=%0d expected 0/%h/%0d",
                 i, emptyO[1], doutO[1], srcO[1], exp2[i], exp2[i][5:4]);
      end
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rdI[g] !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL drained_rd_i dut%0d: got %b expected 0000", g, rdI[g]);
      end
    end
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (emptyO[g] !== 1'b1 || doutO[g] !== 8'h32) begin
        errors++;
        $display("[TB] FAIL drain_hold dut%0d: empty=%b dout=%h expected 1/32", g, emptyO[g], doutO[g]);
      end
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    logic [7:0] expSeq [3];
    expSeq[0] = 8'h10;
    expSeq[1] = 8'h01;
    expSeq[2] = 8'h11;
    rst = 1'b1;
    rdDs[0] = 1'b0;
    rdDs[1] = 1'b0;
    clearModel();
    tick();
    loadPort(0, 0, 2, 8'h00);
    loadPort(0, 1, 2, 8'h10);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      pulses += $countones(rdI[0]);
      tick();
      checks++;
      if (emptyO[0] !== 1'b0 || doutO[0] !== 8'h00 || srcO[0] !== 2'd0) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: empty=%b dout=%h src=%0d expected 0/00/0",
                 c, emptyO[0], doutO[0], srcO[0]);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL stall_pulses: got %0d expected 1", pulses);
    end
    rdDs[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (emptyO[0] !== 1'b0 || doutO[0] !== expSeq[i]) begin
        errors++;
        $display("[TB] FAIL resume[%0d]: empty=%b dout=%h expected 0/%h", i, emptyO[0], doutO[0], expSeq[i]);
      end
    end
    tick();
    checks++;
    if (emptyO[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resume_drain: empty=%b expected 1", emptyO[0]);
    end
  endtask

  task automatic test_single_port();
    rst = 1'b1;
    rdDs[0] = 1'b0;
    rdDs[1] = 1'b0;
    clearModel();
    tick();
    rst = 1'b0;
    rdDs[0] = 1'b1;
    rdDs[1] = 1'b1;
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (emptyO[g] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rd_while_empty dut%0d: empty=%b expected 1", g, emptyO[g]);
      end
      loadPort(g, 2, 5, 8'h20);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (rdI[g] !== 4'b0100) begin
          errors++;
          $display("[TB] FAIL single_rd_i dut%0d[%0d]: got %b expected 0100", g, k, rdI[g]);
        end
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (emptyO[g] !== 1'b0 || doutO[g] !== 8'h20 + 8'(k) || srcO[g] !== 2'd2) begin
          errors++;
          $display("[TB] FAIL single_port dut%0d[%0d]: empty=%b dout=%h src=%0d expected 0/%h/2",
                   g, k, emptyO[g], doutO[g], srcO[g], 8'h20 + 8'(k));
        end
      end
    end
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (emptyO[g] !== 1'b1 || doutO[g] !== 8'h24) begin
        errors++;
        $display("[TB] FAIL single_drain dut%0d: empty=%b dout=%h expected 1/24", g, emptyO[g], doutO[g]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    rdDs[0] = 1'b0;
    rdDs[1] = 1'b0;
    clearModel();
    tick();
    loadPort(0, 1, 2, 8'h10);
    loadPort(0, 3, 1, 8'h30);
    rst = 1'b0;
    tick();
    checks++;
    if (emptyO[0] !== 1'b0 || doutO[0] !== 8'h10 || srcO[0] !== 2'd1) begin
      errors++;
      $display("[TB] FAIL mid_staged: empty=%b dout=%h src=%0d expected 0/10/1", emptyO[0], doutO[0], srcO[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rdI[0] !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mid_rst_rd_i: got %b expected 0000", rdI[0]);
    end
    tick();
    checks++;
    if (emptyO[0] !== 1'b1 || doutO[0] !== 8'h00 || srcO[0] !== 2'd0) begin
      errors++;
      $display("[TB] FAIL mid_rst_drop: empty=%b dout=%h src=%0d expected 1/00/0", emptyO[0], doutO[0], srcO[0]);
    end
    rst = 1'b0;
    rdDs[0] = 1'b1;
    #1;
    checks++;
    if (rdI[0] !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL mid_after_rd_i: got %b expected 0010", rdI[0]);
    end
    tick();
    checks++;
    if (emptyO[0] !== 1'b0 || doutO[0] !== 8'h11 || srcO[0] !== 2'd1) begin
      errors++;
      $display("[TB] FAIL mid_after_word: empty=%b dout=%h src=%0d expected 0/11/1", emptyO[0], doutO[0], srcO[0]);
    end
    tick();
    checks++;
    if (emptyO[0] !== 1'b0 || doutO[0] !== 8'h30 || srcO[0] !== 2'd3) begin
      errors++;
      $display("[TB] FAIL mid_next_port: empty=%b dout=%h src=%0d expected 0/30/3", emptyO[0], doutO[0], srcO[0]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single_port();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prga_fifo_rr_arbiter.md
PRGA_FIFO_RR_ARBITER -- requirements
Module: prga_fifo_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of each data word.
REQ-002 The block SHALL have parameter NUM_PORTS, default 4, number of upstream lookahead FIFO read ports, legal range 2..8.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, maximum consecutive pops from one port before rotation, legal range 1..255.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 Port clk, input, 1, clock; all state updates on rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port empty_i, input, NUM_PORTS, per-port upstream empty; bit p low means dout_i slice p is valid (lookahead).
REQ-008 Port rd_i, output, NUM_PORTS, per-port upstream pop; at most one bit high per cycle.
REQ-009 Port dout_i, input, NUM_PORTS*DATA_WIDTH, upstream data; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port empty, output, 1, downstream lookahead empty flag.
REQ-011 Port rd, input, 1, downstream pop; consumes dout in the same cycle when empty is low.
REQ-012 Port dout, output, DATA_WIDTH, downstream data, valid whenever empty is low.
REQ-013 Port src, output, max(1, clog2(NUM_PORTS)), index of the port dout came from, valid whenever empty is low.

Function
REQ-014 The block SHALL hold one output stage register (valid, data, src); empty SHALL equal NOT valid.
REQ-015 The stage SHALL be loadable in a cycle when it is invalid or when rd is high and it is valid (consume-and-refill, sustaining 1 word/cycle).
REQ-016 In a loadable cycle with at least one empty_i bit low, the block SHALL assert exactly one rd_i bit for the selected port and load dout_i slice and port index into the stage on that edge.
REQ-017 rd_i SHALL be combinational from empty_i, stage state, rd, ptr and burst_cnt; rd_i SHALL be all-zero when not loadable or when all empty_i are high.
REQ-018 Selection SHALL scan ports cyclically, first non-empty wins; scan starts at ptr when burst_cnt < MAX_BURST, else at (ptr+1) mod NUM_PORTS, wrapping through all ports including ptr.
REQ-019 On a pop from port p: burst_cnt SHALL become burst_cnt+1 if p == ptr and burst_cnt < MAX_BURST, else 1; ptr SHALL become p.
REQ-020 burst_cnt SHALL be 8 bits; it SHALL never exceed MAX_BURST.
REQ-021 Latency: first non-empty input in cycle t (stage empty) SHALL produce empty low in cycle t+1.
REQ-022 While empty is low and rd is low, dout and src SHALL stay constant and no rd_i SHALL assert.
REQ-023 rd asserted while empty is high SHALL be ignored.
REQ-024 When the stage is consumed and no port is non-empty, empty SHALL go high the next cycle; dout SHALL hold its last value.
REQ-025 A single non-empty port SHALL be served back-to-back with no bubbles regardless of MAX_BURST.
REQ-026 No word SHALL be lost, duplicated or reordered within a port.

Reset
REQ-027 During rst: stage valid = 0 (empty = 1), rd_i = 0, ptr = NUM_PORTS-1, burst_cnt = MAX_BURST, dout = 0, src = 0.
REQ-028 rst asserted mid-operation SHALL discard the staged word; upstream words not yet popped SHALL remain upstream.
REQ-029 First selection after rst deasserts SHALL start scanning at port 0.

Verification
REQ-030 Reset: all empty_i low, rst high 2 cycles -> rd_i = 0, empty = 1 throughout; first cycle after release rd_i = 4'b0001.
REQ-031 NUM_PORTS=4, MAX_BURST=1, port p preloaded with 3 words 8'h{p}{k}, rd held 1 -> dout 00,10,20,30,01,11,21,31,02,12,22,32 on 12 consecutive cycles, src 0,1,2,3 repeating, first word one cycle after release.
REQ-032 Same preload, MAX_BURST=2 -> dout 00,01,10,11,20,21,30,31,02,12,22,32, no bubbles.
REQ-033 Backpressure: rd=0 for 5 cycles with stage loaded -> exactly one rd_i pulse, dout/src constant; rd=1 afterwards -> sequence continues with no loss or duplicate.
REQ-034 Only port 2 non-empty with 5 words, MAX_BURST=2 -> 5 back-to-back outputs, src=2 each, rd_i = 4'b0100 each pop.
REQ-035 rst pulsed while empty low -> next cycle empty = 1, staged word dropped, next pop from lowest-index non-empty port.
